// File: rtl/node_run_sequencer_if.sv
// Handshake and status bundle between a node's job requester and its run sequencer.
// master = requester / node side, slave = node_run_sequencer.
interface node_run_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [ADDR_W-1:0] start_offset;
  logic              fin;
  logic              axi_idle;
  logic              activate;
  logic              core_res_n;
  logic [ADDR_W-1:0] axi_offset;
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [CNT_W-1:0]  run_cycles;

  modport master (
    output start, start_offset, fin, axi_idle,
    input  activate, core_res_n, axi_offset, busy, done, timed_out, run_cycles
  );

  modport slave (
    input  start, start_offset, fin, axi_idle,
    output activate, core_res_n, axi_offset, busy, done, timed_out, run_cycles
  );
endinterface

// File: rtl/node_run_sequencer.sv
// Sequences one job on a clock-gated PicoRV node: enable clock, hold core reset,
// run until fin or watchdog, drain AXI traffic, gate off and pulse done.
module node_run_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int RST_HOLD     = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 0,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 res,
  node_run_sequencer_if.slave seq_if
);
  localparam int HOLD_N  = (RST_HOLD < 1) ? 1 : RST_HOLD;
  localparam int DRAIN_N = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int CNT_MAX = (HOLD_N > DRAIN_N) ? HOLD_N : DRAIN_N;
  localparam int SEQ_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [SEQ_W-1:0] HOLD_LAST  = SEQ_W'(HOLD_N - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_N - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, ENABLE, RUN, DRAIN, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic              idle_seen_q, idle_seen_d;
  logic              activate_q, activate_d;
  logic              core_res_n_q, core_res_n_d;
  logic [ADDR_W-1:0] axi_offset_q, axi_offset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;

  always_comb begin
    state_d      = state_q;
    seq_cnt_d    = seq_cnt_q;
    idle_seen_d  = idle_seen_q;
    activate_d   = activate_q;
    core_res_n_d = core_res_n_q;
    axi_offset_d = axi_offset_q;
    timed_out_d  = timed_out_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      IDLE: begin
        if (seq_if.start) begin
          axi_offset_d = seq_if.start_offset;
          run_cycles_d = '0;
          timed_out_d  = 1'b0;
          activate_d   = 1'b1;
          seq_cnt_d    = '0;
          state_d      = ENABLE;
        end
      end
      ENABLE: begin
        if (seq_cnt_q == HOLD_LAST) begin
          core_res_n_d = 1'b1;
          state_d      = RUN;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + 1'b1;
        end
        // fin has priority over a coinciding watchdog expiry
        if (seq_if.fin) begin
          seq_cnt_d   = '0;
          idle_seen_d = 1'b0;
          state_d     = DRAIN;
        end else if ((TIMEOUT != 0) && (run_cycles_q == TO_LAST)) begin
          timed_out_d = 1'b1;
          seq_cnt_d   = '0;
          idle_seen_d = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // The cycle axi_idle is first seen is the first counted drain cycle
        if (idle_seen_q || seq_if.axi_idle) begin
          idle_seen_d = 1'b1;
          if (seq_cnt_q == DRAIN_LAST) begin
            activate_d   = 1'b0;
            core_res_n_d = 1'b0;
            state_d      = DONE;
          end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      seq_cnt_q    <= '0;
      idle_seen_q  <= 1'b0;
      activate_q   <= 1'b0;
      core_res_n_q <= 1'b0;
      axi_offset_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      seq_cnt_q    <= seq_cnt_d;
      idle_seen_q  <= idle_seen_d;
      activate_q   <= activate_d;
      core_res_n_q <= core_res_n_d;
      axi_offset_q <= axi_offset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign seq_if.activate   = activate_q;
  assign seq_if.core_res_n = core_res_n_q;
  assign seq_if.axi_offset = axi_offset_q;
  assign seq_if.busy       = busy_q;
  assign seq_if.done       = done_q;
  assign seq_if.timed_out  = timed_out_q;
  assign seq_if.run_cycles = run_cycles_q;
endmodule

// File: tb/tb_node_run_sequencer.sv
// Bench for node_run_sequencer: cycle table for a short job, then directed
// sequences for run length, drain hold, watchdog, collision, mid-run reset, saturation.
module tb_node_run_sequencer;
  logic        clk = 1'b0;
  logic        res;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  node_run_sequencer_if #(.ADDR_W(32), .CNT_W(32)) m_if ();
  node_run_sequencer_if #(.ADDR_W(32), .CNT_W(4))  s_if ();

  node_run_sequencer #(
    .ADDR_W(32), .RST_HOLD(4), .DRAIN_CYCLES(2), .TIMEOUT(20), .CNT_W(32)
  ) u_dut (
    .clk(clk), .res(res), .seq_if(m_if.slave)
  );

  node_run_sequencer #(
    .ADDR_W(32), .RST_HOLD(4), .DRAIN_CYCLES(2), .TIMEOUT(0), .CNT_W(4)
  ) u_sat (
    .clk(clk), .res(res), .seq_if(s_if.slave)
  );

  typedef struct {
    logic        res;
    logic        start;
    logic [31:0] off;
    logic        fin;
    logic        idle;
    logic        act;
    logic        crn;
    logic        busy;
    logic        done;
    logic        to;
    logic [31:0] exp_off;
    logic [31:0] rc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a job on the main DUT and step to the first RUN cycle.
  task automatic enter_run(input logic [31:0] off);
    m_if.start        = 1'b1;
    m_if.start_offset = off;
    tick();
    m_if.start        = 1'b0;
    m_if.start_offset = 32'h0;
    chk("start_act", 64'(m_if.activate), 64'd1);
    chk("start_crn", 64'(m_if.core_res_n), 64'd0);
    chk("start_to_clr", 64'(m_if.timed_out), 64'd0);
    chk("start_rc_clr", 64'(m_if.run_cycles), 64'd0);
    chk("start_off", 64'(m_if.axi_offset), 64'(off));
    repeat (3) tick();
    chk("hold_crn_low", 64'(m_if.core_res_n), 64'd0);
    tick();
    chk("run_crn_high", 64'(m_if.core_res_n), 64'd1);
  endtask

  // Called in the first DRAIN cycle with nothing outstanding.
  task automatic finish_drain();
    m_if.axi_idle = 1'b1;
    tick();
    chk("drain_act", 64'(m_if.activate), 64'd1);
    chk("drain_no_done", 64'(m_if.done), 64'd0);
    tick();
    chk("done_pulse", 64'(m_if.done), 64'd1);
    chk("done_act_off", 64'(m_if.activate), 64'd0);
    chk("done_crn_low", 64'(m_if.core_res_n), 64'd0);
    tick();
    chk("done_one_cycle", 64'(m_if.done), 64'd0);
    chk("idle_busy", 64'(m_if.busy), 64'd0);
  endtask

  initial begin
    res               = 1'b1;
    m_if.start        = 1'b0;
    m_if.start_offset = 32'h0;
    m_if.fin          = 1'b0;
    m_if.axi_idle     = 1'b1;
    s_if.start        = 1'b0;
    s_if.start_offset = 32'h0;
    s_if.fin          = 1'b0;
    s_if.axi_idle     = 1'b1;

    //        res   start off            fin   idle    act   crn   busy  done  to    exp_off        rc
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd2};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd2};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0001_0000, 32'd2};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 32'd2};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 32'd2};

    for (int i = 0; i < 13; i++) begin
      res               = tbl[i].res;
      m_if.start        = tbl[i].start;
      m_if.start_offset = tbl[i].off;
      m_if.fin          = tbl[i].fin;
      m_if.axi_idle     = tbl[i].idle;
      tick();
      chk($sformatf("v%0d.activate", i),   64'(m_if.activate),   64'(tbl[i].act));
      chk($sformatf("v%0d.core_res_n", i), 64'(m_if.core_res_n), 64'(tbl[i].crn));
      chk($sformatf("v%0d.busy", i),       64'(m_if.busy),       64'(tbl[i].busy));
      chk($sformatf("v%0d.done", i),       64'(m_if.done),       64'(tbl[i].done));
      chk($sformatf("v%0d.timed_out", i),  64'(m_if.timed_out),  64'(tbl[i].to));
      chk($sformatf("v%0d.axi_offset", i), 64'(m_if.axi_offset), 64'(tbl[i].exp_off));
      chk($sformatf("v%0d.run_cycles", i), 64'(m_if.run_cycles), 64'(tbl[i].rc));
    end
    res               = 1'b0;
    m_if.start        = 1'b0;
    m_if.start_offset = 32'h0;
    m_if.fin          = 1'b0;
    m_if.axi_idle     = 1'b1;

    // Nominal job: fin in the 10th RUN cycle
    enter_run(32'h0001_0000);
    repeat (9) tick();
    chk("nom_rc9", 64'(m_if.run_cycles), 64'd9);
    m_if.fin = 1'b1;
    tick();
    m_if.fin = 1'b0;
    chk("nom_rc10", 64'(m_if.run_cycles), 64'd10);
    chk("nom_to", 64'(m_if.timed_out), 64'd0);
    finish_drain();
    chk("nom_rc_kept", 64'(m_if.run_cycles), 64'd10);
    chk("nom_off_kept", 64'(m_if.axi_offset), 64'h0001_0000);

    // Drain hold: axi_idle low for 7 DRAIN cycles
    enter_run(32'h0003_0000);
    m_if.axi_idle = 1'b0;
    m_if.fin      = 1'b1;
    tick();
    m_if.fin = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("hold%0d_act", k), 64'(m_if.activate), 64'd1);
      chk($sformatf("hold%0d_done", k), 64'(m_if.done), 64'd0);
    end
    m_if.axi_idle = 1'b1;
    tick();
    chk("hold_cnt1_act", 64'(m_if.activate), 64'd1);
    chk("hold_cnt1_done", 64'(m_if.done), 64'd0);
    tick();
    chk("hold_end_act", 64'(m_if.activate), 64'd0);
    chk("hold_end_done", 64'(m_if.done), 64'd1);
    tick();
    chk("hold_idle_busy", 64'(m_if.busy), 64'd0);

    // Watchdog: no fin, TIMEOUT = 20
    enter_run(32'h0002_0000);
    repeat (19) tick();
    chk("wd_rc19", 64'(m_if.run_cycles), 64'd19);
    chk("wd_not_yet", 64'(m_if.timed_out), 64'd0);
    tick();
    chk("wd_to", 64'(m_if.timed_out), 64'd1);
    chk("wd_rc20", 64'(m_if.run_cycles), 64'd20);
    chk("wd_drain_act", 64'(m_if.activate), 64'd1);
    finish_drain();
    chk("wd_sticky", 64'(m_if.timed_out), 64'd1);

    // Collision: fin in the 20th RUN cycle, start pulses in RUN ignored
    enter_run(32'h0004_0000);
    m_if.start        = 1'b1;
    m_if.start_offset = 32'h0009_9999;
    repeat (19) tick();
    m_if.start        = 1'b0;
    m_if.start_offset = 32'h0;
    chk("col_off_kept", 64'(m_if.axi_offset), 64'h0004_0000);
    m_if.fin = 1'b1;
    tick();
    m_if.fin = 1'b0;
    chk("col_to", 64'(m_if.timed_out), 64'd0);
    chk("col_rc20", 64'(m_if.run_cycles), 64'd20);
    finish_drain();
    chk("col_to_after", 64'(m_if.timed_out), 64'd0);

    // Reset in RUN cycle 5
    enter_run(32'h0005_0000);
    repeat (4) tick();
    chk("rst_pre_rc", 64'(m_if.run_cycles), 64'd4);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("rst_act", 64'(m_if.activate), 64'd0);
    chk("rst_crn", 64'(m_if.core_res_n), 64'd0);
    chk("rst_busy", 64'(m_if.busy), 64'd0);
    chk("rst_rc", 64'(m_if.run_cycles), 64'd0);
    chk("rst_off", 64'(m_if.axi_offset), 64'd0);
    chk("rst_done", 64'(m_if.done), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst_quiet%0d_done", k), 64'(m_if.done), 64'd0);
      chk($sformatf("rst_quiet%0d_busy", k), 64'(m_if.busy), 64'd0);
    end

    // Saturation: CNT_W = 4, no watchdog, fin in the 30th RUN cycle
    s_if.start        = 1'b1;
    s_if.start_offset = 32'h0006_0000;
    tick();
    s_if.start = 1'b0;
    repeat (4) tick();
    chk("sat_crn", 64'(s_if.core_res_n), 64'd1);
    repeat (29) tick();
    chk("sat_rc29", 64'(s_if.run_cycles), 64'd15);
    chk("sat_no_wd", 64'(s_if.timed_out), 64'd0);
    chk("sat_still_run", 64'(s_if.activate), 64'd1);
    s_if.fin = 1'b1;
    tick();
    s_if.fin = 1'b0;
    chk("sat_rc_hold", 64'(s_if.run_cycles), 64'd15);
    tick();
    tick();
    chk("sat_done", 64'(s_if.done), 64'd1);
    tick();
    chk("sat_rc_final", 64'(s_if.run_cycles), 64'd15);
    chk("sat_off", 64'(s_if.axi_offset), 64'h0006_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
